// File: rtl/seg_static_ctrl.sv
// seg_static_ctrl: static 6-digit common-anode hex counter display; SEG_DP_BLINK_EN lights dp on odd digits
module seg_static_ctrl #(
    parameter logic [24:0] TIME_MAX = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic [5:0] sel,
    output logic [7:0] seg
);
    logic [24:0] cnt;
    logic        flag;
    logic [3:0]  num;
    logic [6:0]  dec;
    logic        dp;
    always_comb begin
        dec = 7'h7F;
        case (num)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            4'hF: dec = 7'h0E;
            default: dec = 7'h7F;
        endcase
    end
`ifdef SEG_DP_BLINK_EN
    assign dp = ~num[0];
`else
    assign dp = 1'b1;
`endif
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt  <= '0;
            flag <= 1'b0;
            num  <= '0;
            sel  <= '0;
            seg  <= 8'hFF;
        end else begin
            cnt  <= (cnt == TIME_MAX) ? '0 : cnt + 25'd1;
            flag <= (cnt == TIME_MAX - 25'd1);
            num  <= flag ? num + 4'd1 : num;
            sel  <= 6'h3F;
            seg  <= {dp, dec};
        end
    end
endmodule

// File: tb/tb_seg_static_ctrl.sv
// tb_seg_static_ctrl: scoreboard bench; expected display derived from clocks elapsed since reset release
module tb_seg_static_ctrl;
    localparam int TM = 24;
    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [5:0] sel;
    logic [7:0] seg;
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #10 sys_clk = ~sys_clk;

    seg_static_ctrl #(.TIME_MAX(25'(TM))) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .sel(sel),
        .seg(seg)
    );

    // After the n-th released edge the display shows digit floor((n-1)/(TM+1)) mod 16
    task automatic issue(input logic r);
        int d;
        logic [7:0] s;
        exp_t e;
        sys_rst = r;
        if (r) begin
            n = 0;
            e = {6'h00, 8'hFF};
        end else begin
            n++;
            d = ((n - 1) / (TM + 1)) % 16;
            s = lut[d];
`ifdef SEG_DP_BLINK_EN
            s[7] = ~d[0];
`endif
            e = {6'h3F, s};
        end
        q.push_back(e);
    endtask

    function automatic int digit();
        return ((n - 1) / (TM + 1)) % 16;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #5;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: no expected entry at %0t", $time);
            end else begin
                e = q.pop_front();
                checks++;
                if (sel !== e.sel) begin
                    errors++;
                    $display("FAIL sel at %0t: got %h expected %h", $time, sel, e.sel);
                end
                checks++;
                if (seg !== e.seg) begin
                    errors++;
                    $display("FAIL seg at %0t: got %h expected %h", $time, seg, e.seg);
                end
            end
        end
    end

    initial begin
        issue(1'b1);
        for (int i = 0; i < 16 * (TM + 1) + 60; i++) begin
            @(negedge sys_clk);
            issue(1'b0);
        end
        for (int i = 0; i < 500 && !(digit() == 7 && ((n - 1) % (TM + 1)) == 12); i++) begin
            @(negedge sys_clk);
            issue(1'b0);
        end
        repeat (2) begin
            @(negedge sys_clk);
            issue(1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'($urandom_range(30, 400)); i++) begin
                @(negedge sys_clk);
                issue(1'b0);
            end
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                @(negedge sys_clk);
                issue(1'b1);
            end
        end
        for (int i = 0; i < 3 * (TM + 1); i++) begin
            @(negedge sys_clk);
            issue(1'b0);
        end
        @(posedge sys_clk);
        #8;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
